// File: rtl/one_pkg.sv
// ---------------------------------------------------------------------------
// one_pkg
// Shared constants for the `one` adder pipeline and its credit adapter.
//   WIDTH   : operand/result width of the adder
//   LATENCY : adder input-to-output latency in cycles (>= 1)
//   word_t  : one operand/result word
// ---------------------------------------------------------------------------
package one_pkg;

  localparam int WIDTH   = 32;
  localparam int LATENCY = 2;

  typedef logic [WIDTH-1:0] word_t;

endpackage : one_pkg

// File: rtl/one_credit_adapter_if.sv
// ---------------------------------------------------------------------------
// one_credit_adapter_if
// Upstream operand handshake plus downstream result handshake of the adapter.
//   in_valid/in_ready/in_x/in_y     : operand pair channel (into the adapter)
//   out_valid/out_ready/out_data    : sum channel (out of the adapter)
// Modports:
//   slave  : the adapter side
//   master : the producer/consumer side (testbench or parent)
// ---------------------------------------------------------------------------
interface one_credit_adapter_if #(
  parameter int WIDTH = one_pkg::WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface : one_credit_adapter_if

// File: rtl/one_credit_adapter_chk.sv
// ---------------------------------------------------------------------------
// one_credit_adapter_chk
// Simulation-only property for the credit scheme: a pipeline result must never
// arrive while the result FIFO is full.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : adder result being written this cycle
//   full_i     : result FIFO full
// ---------------------------------------------------------------------------
module one_credit_adapter_chk (
  input logic clk,
  input logic rst_n,
  input logic push_i,
  input logic full_i
);

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_i))
    else $error("result pushed into full FIFO");

endmodule : one_credit_adapter_chk

// File: rtl/one_result_fifo.sv
// ---------------------------------------------------------------------------
// one_result_fifo
// DEPTH x WIDTH result buffer. Pointers wrap at DEPTH-1, so DEPTH need not be
// a power of two. Control state is reset, storage is not.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_i       : write push_data_i at the tail
//   pop_i        : drop the head entry
//   count_o      : number of stored entries (0..DEPTH)
//   full_o       : count_o == DEPTH
//   valid_o      : head entry present (count_o != 0)
//   head_o       : head entry data
// ---------------------------------------------------------------------------
module one_result_fifo #(
  parameter  int WIDTH = one_pkg::WIDTH,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Next-state for pointers and entry count.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      wr_d = next_ptr(wr_q);
    end else begin
      wr_d = wr_q;
    end
    if (pop_i) begin
      rd_d = next_ptr(rd_q);
    end else begin
      rd_d = rd_q;
    end
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage write; contents are meaningless until counted.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign valid_o = (cnt_q != '0);
  assign head_o  = mem_q[rd_q];

endmodule : one_result_fifo

// File: rtl/one_credit_adapter.sv
// ---------------------------------------------------------------------------
// one_credit_adapter
// Valid/ready front end and result buffer around the fixed-latency,
// non-stallable `one` adder (instantiated by the parent). An operand pair is
// only accepted when a FIFO slot is guaranteed for its sum, so the adder never
// has to stall.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : operand (in_*) and result (out_*) handshakes, slave side
//   add_x/y    : operands to the adder, combinational copies of in_x/in_y
//   add_out    : adder sum, valid LATENCY cycles after acceptance
//   occupancy  : buffered results + in-flight ops (debug)
// ---------------------------------------------------------------------------
module one_credit_adapter #(
  parameter  int WIDTH   = one_pkg::WIDTH,
  parameter  int LATENCY = one_pkg::LATENCY,
  parameter  int DEPTH   = 4,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int IW      = $clog2(LATENCY + 1),
  localparam int SW      = CW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  one_credit_adapter_if.slave   bus,
  output logic [WIDTH-1:0]      add_x,
  output logic [WIDTH-1:0]      add_y,
  input  logic [WIDTH-1:0]      add_out,
  output logic [CW-1:0]         occupancy
);

  logic               accept;
  logic               push;
  logic               pop;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [IW-1:0]      inflight_q, inflight_d;
  logic [CW-1:0]      count;
  logic               full;
  logic [SW-1:0]      credits_used;

  // Credits are counted from registered state only, so out_ready never
  // reaches in_ready combinationally; a freed slot shows up one cycle later.
  assign credits_used = SW'(count) + SW'(inflight_q);
  assign bus.in_ready = (credits_used < SW'(DEPTH));
  assign occupancy    = credits_used[CW-1:0];

  assign accept = bus.in_valid & bus.in_ready;
  assign push   = vld_q[LATENCY-1];
  assign pop    = bus.out_valid & bus.out_ready;

  // The adder runs every cycle; only results tagged by vld_q are kept.
  assign add_x = bus.in_x;
  assign add_y = bus.in_y;

  // Shadow valid pipe and in-flight counter next-state.
  always_comb begin
    vld_d      = '0;
    inflight_d = inflight_q;
    vld_d[0]   = accept;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end
    case ({accept, push})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Shadow valid pipe and in-flight counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      inflight_q <= '0;
    end else begin
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
    end
  end

  one_result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (add_out),
    .pop_i       (pop),
    .count_o     (count),
    .full_o      (full),
    .valid_o     (bus.out_valid),
    .head_o      (bus.out_data)
  );

  one_credit_adapter_chk u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .full_i (full)
  );

endmodule : one_credit_adapter

// File: tb/tb_one_credit_adapter.sv
// ---------------------------------------------------------------------------
// tb_one_credit_adapter
// Directed bench for one_credit_adapter (LATENCY=2, DEPTH=4) with a behavioural
// `one` adder: a LATENCY-deep register pipeline computing x + y, no reset.
// ---------------------------------------------------------------------------
module tb_one_credit_adapter;
  import one_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  one_credit_adapter_if #(.WIDTH(WIDTH)) bus ();

  word_t         add_x, add_y, add_out;
  logic [CW-1:0] occupancy;
  word_t         pipe_q [LATENCY];

  // Behavioural adder pipeline.
  always_ff @(posedge clk) begin
    pipe_q[0] <= add_x + add_y;
    for (int k = 1; k < LATENCY; k++) begin
      pipe_q[k] <= pipe_q[k-1];
    end
  end
  assign add_out = pipe_q[LATENCY-1];

  one_credit_adapter #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_out   (add_out),
    .occupancy (occupancy)
  );

  int    checks   = 0;
  int    failures = 0;
  word_t exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop everything in exp_q with out_ready=1, comparing in order.
  task automatic drain(input string tag);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (bus.out_valid) begin
        check({tag, "_data"}, bus.out_data, exp_q.pop_front());
      end
      tick();
    end
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_empty_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_empty_occ"}, 32'(occupancy), 32'd0);
  endtask

  initial begin
    int    nacc;
    int    n_sent;
    int    n_res;
    int    first_c;
    int    last_c;
    logic  got;
    word_t x;
    word_t y;

    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.out_ready = 1'b0;

    // ---- reset state ----
    repeat (3) tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    rst_n = 1'b1;
    tick();

    // ---- single op 3+4, result 3 cycles after acceptance ----
    bus.in_valid  = 1'b1;
    bus.in_x      = 32'd3;
    bus.in_y      = 32'd4;
    bus.out_ready = 1'b1;
    check("single_in_ready", 32'(bus.in_ready), 32'd1);
    check("single_add_x", add_x, 32'd3);
    check("single_add_y", add_y, 32'd4);
    tick();
    bus.in_valid = 1'b0;
    check("single_valid_t1", 32'(bus.out_valid), 32'd0);
    check("single_occ_t1", 32'(occupancy), 32'd1);
    tick();
    check("single_valid_t2", 32'(bus.out_valid), 32'd0);
    tick();
    check("single_valid_t3", 32'(bus.out_valid), 32'd1);
    check("single_data", bus.out_data, 32'd7);
    tick();
    check("single_valid_after", 32'(bus.out_valid), 32'd0);
    check("single_occ_after", 32'(occupancy), 32'd0);

    // ---- carry dropped ----
    bus.in_valid = 1'b1;
    bus.in_x     = 32'hFFFF_FFFF;
    bus.in_y     = 32'd2;
    tick();
    bus.in_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.out_valid) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("wrap_seen", 32'(got), 32'd1);
    check("wrap_data", bus.out_data, 32'h0000_0001);
    tick();

    // ---- back-pressure: exactly DEPTH accepted ----
    bus.out_ready = 1'b0;
    nacc = 0;
    for (int c = 0; c < 8; c++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = word_t'(nacc + 1);
      bus.in_y     = word_t'(nacc + 1);
      got          = bus.in_ready;
      tick();
      if (got) begin
        nacc++;
        exp_q.push_back(word_t'(2 * nacc));
      end
    end
    bus.in_valid = 1'b0;
    check("bp_accepted", 32'(nacc), 32'd4);
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp_occupancy", 32'(occupancy), 32'd4);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    check("bp_ready_same_cycle", 32'(bus.in_ready), 32'd0);
    check("bp_first", bus.out_data, exp_q.pop_front());
    tick();
    check("bp_ready_next_cycle", 32'(bus.in_ready), 32'd1);
    drain("bp");

    // ---- streaming 100 back-to-back ops ----
    bus.out_ready = 1'b1;
    n_sent  = 0;
    n_res   = 0;
    first_c = -1;
    last_c  = -1;
    for (int c = 0; c < 120; c++) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected", 32'(bus.out_valid), 32'd0);
        end else begin
          check("stream_data", bus.out_data, exp_q.pop_front());
        end
        n_res++;
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      if (n_sent < 100) begin
        x = word_t'(n_sent * 7 + 5);
        y = word_t'(n_sent) << 20;
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_y     = y;
        check("stream_in_ready", 32'(bus.in_ready), 32'd1);
        exp_q.push_back(x + y);
        n_sent++;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
    end
    check("stream_results", 32'(n_res), 32'd100);
    check("stream_span", 32'(last_c - first_c), 32'd99);
    drain("stream");

    // ---- random out_ready: push/pop at count=DEPTH-1, scoreboard ----
    for (int c = 0; c < 300; c++) begin
      bus.in_valid  = 1'b1;
      bus.in_x      = $urandom();
      bus.in_y      = $urandom();
      bus.out_ready = 1'($urandom_range(0, 1));
      check("rand_occupancy", 32'(occupancy), 32'(exp_q.size()));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected", 32'(bus.out_valid), 32'd0);
        end else begin
          check("rand_data", bus.out_data, exp_q.pop_front());
        end
      end
      if (bus.in_ready) begin
        exp_q.push_back(bus.in_x + bus.in_y);
      end
      tick();
    end
    drain("rand");

    // ---- reset with 2 in flight, 2 buffered ----
    bus.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = word_t'(100 + c);
      bus.in_y     = 32'd1;
      tick();
    end
    bus.in_valid = 1'b0;
    check("mid_occupancy", 32'(occupancy), 32'd4);
    check("mid_out_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_occupancy", 32'(occupancy), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      check("mid_no_stale", 32'(bus.out_valid), 32'd0);
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_x     = 32'd10;
    bus.in_y     = 32'd20;
    tick();
    exp_q.push_back(32'd30);
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_one_credit_adapter
